// File: rtl/multdiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM state
// encodings, the default iteration count and the most negative operand value.
package multdiv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int          ITER_DEFAULT = 32;
    localparam logic [31:0] INT_MIN      = 32'h8000_0000;

endpackage

// File: rtl/multdiv_counter.sv
// Step counter for the multiply/divide unit. Cleared on every start, counts
// while enabled and saturates at the terminal count so it can never wrap.
module multdiv_counter #(
    parameter int CW   = 6,
    parameter int TERM = 31
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc_o = (count_q == CW'(TERM));

    // Next count: clear wins over enable; hold once the terminal count is reached.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide unit. Multiply is radix-2 Booth, divide is
// non-restoring on operand magnitudes with the quotient sign applied at the end.
// A start pulse in cycle T yields a one-cycle data_resultRDY in cycle T+ITER+1.
module multdiv_seq
    import multdiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = ITER_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             multdiv_start,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    state_e state_q, state_d;

    // Booth register layout: {accumulator (WIDTH+1), multiplier (WIDTH), q-1}.
    // The extra accumulator bit absorbs subtracting the most negative multiplicand.
    logic [2*WIDTH+1:0] booth_q, booth_next;
    logic [WIDTH:0]     mcand_q;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH-1:0] product;

    // Divide: signed partial remainder two bits wider than the magnitudes.
    logic [WIDTH+1:0]   rem_q, rem_next, rem_sh;
    logic [WIDTH-1:0]   quo_q, quo_next, dvsr_q;
    logic               neg_q, dz_q, ovf_q;

    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               busy, count_tc, finish;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     prod_hi;

    assign multdiv_start  = ctrl_MULT | ctrl_DIV;
    assign busy           = (state_q == ST_MULT) || (state_q == ST_DIV);
    assign finish         = busy && count_tc && !multdiv_start;
    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == ST_DONE);
    assign mag_a          = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign mag_b          = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    multdiv_counter #(
        .CW   (6),
        .TERM (ITER - 1)
    ) u_counter (
        .clk_i  (clock),
        .rst_ni (reset),
        .clr_i  (multdiv_start),
        .en_i   (busy),
        .tc_o   (count_tc)
    );

    // Next state: any start (re)launches an op, multiply taking priority.
    always_comb begin
        state_d = state_q;
        if (multdiv_start) begin
            state_d = ctrl_MULT ? ST_MULT : ST_DIV;
        end else begin
            case (state_q)
                ST_MULT, ST_DIV: if (count_tc) state_d = ST_DONE;
                ST_DONE:         state_d = ST_IDLE;
                default:         state_d = state_q;
            endcase
        end
    end

    // One Booth step: add/subtract the multiplicand, then arithmetic shift right.
    always_comb begin
        case (booth_q[1:0])
            2'b01:   booth_sum = booth_q[2*WIDTH+1:WIDTH+1] + mcand_q;
            2'b10:   booth_sum = booth_q[2*WIDTH+1:WIDTH+1] - mcand_q;
            default: booth_sum = booth_q[2*WIDTH+1:WIDTH+1];
        endcase
        booth_next = {booth_sum[WIDTH], booth_sum, booth_q[WIDTH:1]};
        product    = {booth_sum, booth_q[WIDTH:2]};
        prod_hi    = product[2*WIDTH-1:WIDTH-1];
    end

    // One non-restoring step: shift in the next dividend bit, add or subtract by remainder sign.
    always_comb begin
        rem_sh   = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
        rem_next = rem_q[WIDTH+1] ? (rem_sh + {2'b00, dvsr_q}) : (rem_sh - {2'b00, dvsr_q});
        quo_next = {quo_q[WIDTH-2:0], ~rem_next[WIDTH+1]};
    end

    // Final result, captured only on the step that enters DONE.
    always_comb begin
        result_d = result_q;
        exc_d    = exc_q;
        if (finish) begin
            if (state_q == ST_MULT) begin
                result_d = product[WIDTH-1:0];
                exc_d    = !((&prod_hi) || (~|prod_hi));
            end else if (dz_q) begin
                result_d = '0;
                exc_d    = 1'b1;
            end else begin
                result_d = neg_q ? (~quo_next + 1'b1) : quo_next;
                exc_d    = ovf_q;
            end
        end
    end

    // Control and result registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    // Datapath: operands latched on start, then one iteration per busy cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            booth_q <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (multdiv_start) begin
            booth_q <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
            mcand_q <= {data_operandA[WIDTH-1], data_operandA};
            rem_q   <= '0;
            quo_q   <= mag_a;
            dvsr_q  <= mag_b;
            neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_q    <= (data_operandB == '0);
            ovf_q   <= (data_operandA == INT_MIN) && (data_operandB == '1);
        end else if (state_q == ST_MULT) begin
            booth_q <= booth_next;
        end else if (state_q == ST_DIV) begin
            rem_q   <= rem_next;
            quo_q   <= quo_next;
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: expected results are queued when an op
// is launched and popped when data_resultRDY is observed.
module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        multdiv_start;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    multdiv_seq dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .multdiv_start  (multdiv_start),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    // Reference behaviour for randomised ops.
    function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (m) begin
            p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            r = p[31:0];
            e = !((p[63:31] == '0) || (p[63:31] == '1));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = sa / sb;
            e = 1'b0;
        end
    endfunction

    // Start pulse held for exactly one cycle; 'now' starts in the current cycle.
    task automatic pulse(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input bit now);
        if (!now) @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Cycles from the pulse cycle to RDY (first sample is cycle T+1); -1 on timeout.
    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (data_resultRDY === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        bit seen;
        repeat (3) @(negedge clock);
        n_checks++;
        if (data_result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", data_result); end
        n_checks++;
        if (data_exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc: got %b expected 0", data_exception); end
        n_checks++;
        if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", data_resultRDY); end
        // Start pulse during reset: visible combinationally, but must not launch an op.
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd1;
        #1;
        n_checks++;
        if (multdiv_start !== 1'b1) begin n_fail++; $display("FAIL start_comb: got %b expected 1", multdiv_start); end
        @(negedge clock);
        ctrl_DIV = 1'b0;
        reset    = 1'b1;
        seen     = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL reset_override: got rdy pulse expected none"); end
        $display("op RESET done: result=%h exc=%b", data_result, data_exception);
    endtask

    task automatic test_mult();
        logic [31:0] ta [3] = '{32'd7, 32'h0001_0000, 32'h7FFF_FFFF};
        logic [31:0] tb [3] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1};
        logic [31:0] er [3] = '{32'hFFFF_FFEB, 32'd0, 32'h7FFF_FFFF};
        logic        ee [3] = '{1'b0, 1'b1, 1'b0};
        int   lat;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{res: er[i], exc: ee[i]});
            pulse(1'b1, 1'b0, ta[i], tb[i], 1'b0);
            wait_rdy(lat);
            n_checks++;
            if (lat !== 33) begin n_fail++; $display("FAIL mult_latency[%0d]: got %0d expected 33", i, lat); end
            e = sb_q.pop_front();
            n_checks++;
            if (data_result !== e.res) begin n_fail++; $display("FAIL mult_result[%0d]: got %h expected %h", i, data_result, e.res); end
            n_checks++;
            if (data_exception !== e.exc) begin n_fail++; $display("FAIL mult_exc[%0d]: got %b expected %b", i, data_exception, e.exc); end
            $display("op MULT A=%h B=%h -> result=%h exc=%b lat=%0d", ta[i], tb[i], data_result, data_exception, lat);
            @(negedge clock);
            n_checks++;
            if (data_resultRDY !== 1'b0 || data_result !== e.res) begin
                n_fail++; $display("FAIL mult_hold[%0d]: got rdy=%b result=%h expected rdy=0 result=%h", i, data_resultRDY, data_result, e.res);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] ta [3] = '{32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
        logic [31:0] tb [3] = '{32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] er [3] = '{32'hFFFF_FFFD, 32'd0, 32'h8000_0000};
        logic        ee [3] = '{1'b0, 1'b1, 1'b1};
        int   lat;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{res: er[i], exc: ee[i]});
            pulse(1'b0, 1'b1, ta[i], tb[i], 1'b0);
            wait_rdy(lat);
            n_checks++;
            if (lat !== 33) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
            e = sb_q.pop_front();
            n_checks++;
            if (data_result !== e.res) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", i, data_result, e.res); end
            n_checks++;
            if (data_exception !== e.exc) begin n_fail++; $display("FAIL div_exc[%0d]: got %b expected %b", i, data_exception, e.exc); end
            $display("op DIV A=%h B=%h -> result=%h exc=%b lat=%0d", ta[i], tb[i], data_result, data_exception, lat);
            @(negedge clock);
            n_checks++;
            if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL div_rdy_width[%0d]: got %b expected 0", i, data_resultRDY); end
        end
    endtask

    task automatic test_abort();
        int   lat;
        exp_t e;
        pulse(1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
        repeat (8) @(negedge clock);
        sb_q.push_back('{res: 32'd10, exc: 1'b0});
        pulse(1'b0, 1'b1, 32'd100, 32'd10, 1'b0);
        wait_rdy(lat);
        n_checks++;
        if (lat !== 33) begin n_fail++; $display("FAIL abort_latency: got %0d expected 33", lat); end
        e = sb_q.pop_front();
        n_checks++;
        if (data_result !== e.res) begin n_fail++; $display("FAIL abort_result: got %h expected %h", data_result, e.res); end
        n_checks++;
        if (data_exception !== e.exc) begin n_fail++; $display("FAIL abort_exc: got %b expected %b", data_exception, e.exc); end
        $display("op DIV(abort MULT) A=100 B=10 -> result=%h exc=%b lat=%0d", data_result, data_exception, lat);
        @(negedge clock);
        n_checks++;
        if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL abort_rdy_width: got %b expected 0", data_resultRDY); end
    endtask

    task automatic test_reset_mid_op();
        int   lat;
        bit   seen;
        exp_t e;
        pulse(1'b1, 1'b0, 32'd5, 32'd5, 1'b0);
        repeat (14) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (data_result !== 32'd0) begin n_fail++; $display("FAIL midreset_result: got %h expected 0", data_result); end
        n_checks++;
        if (data_exception !== 1'b0) begin n_fail++; $display("FAIL midreset_exc: got %b expected 0", data_exception); end
        reset = 1'b1;
        seen  = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL midreset_rdy: got rdy pulse expected none"); end
        $display("op MULT 5*5 aborted by reset: result=%h exc=%b", data_result, data_exception);
        sb_q.push_back('{res: 32'd4, exc: 1'b0});
        pulse(1'b1, 1'b0, 32'd2, 32'd2, 1'b0);
        wait_rdy(lat);
        n_checks++;
        if (lat !== 33) begin n_fail++; $display("FAIL postreset_latency: got %0d expected 33", lat); end
        e = sb_q.pop_front();
        n_checks++;
        if (data_result !== e.res || data_exception !== e.exc) begin
            n_fail++; $display("FAIL postreset_result: got %h/%b expected %h/%b", data_result, data_exception, e.res, e.exc);
        end
        $display("op MULT A=2 B=2 -> result=%h exc=%b lat=%0d", data_result, data_exception, lat);
        @(negedge clock);
    endtask

    task automatic test_both_pulses();
        int   lat;
        exp_t e;
        sb_q.push_back('{res: 32'd18, exc: 1'b0});
        pulse(1'b1, 1'b1, 32'd6, 32'd3, 1'b0);
        wait_rdy(lat);
        n_checks++;
        if (lat !== 33) begin n_fail++; $display("FAIL both_latency: got %0d expected 33", lat); end
        e = sb_q.pop_front();
        n_checks++;
        if (data_result !== e.res || data_exception !== e.exc) begin
            n_fail++; $display("FAIL both_result: got %h/%b expected %h/%b", data_result, data_exception, e.res, e.exc);
        end
        $display("op MULT+DIV A=6 B=3 -> result=%h exc=%b lat=%0d", data_result, data_exception, lat);
        @(negedge clock);
        data_operandA = 32'h1234_5678;
        data_operandB = 32'h0000_0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            n_checks++;
            if (data_resultRDY !== 1'b0 || data_result !== e.res) begin
                n_fail++; $display("FAIL operand_ignore[%0d]: got rdy=%b result=%h expected rdy=0 result=%h", k, data_resultRDY, data_result, e.res);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        exp_t        e;
        bit          m;
        logic [31:0] a, b, r;
        logic        x;
        for (int i = 0; i < 8; i++) begin
            m = 1'($urandom_range(0, 1));
            a = (i == 2) ? 32'h8000_0000 : $urandom;
            b = (i == 5) ? 32'd0 : ((i % 2) == 1 ? (32'($urandom_range(0, 40)) - 32'd20) : $urandom);
            model(m, a, b, r, x);
            sb_q.push_back('{res: r, exc: x});
            pulse(m, !m, a, b, i > 0);
            wait_rdy(lat);
            n_checks++;
            if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected 33", i, lat); end
            e = sb_q.pop_front();
            n_checks++;
            if (data_result !== e.res || data_exception !== e.exc) begin
                n_fail++; $display("FAIL b2b_result[%0d]: got %h/%b expected %h/%b", i, data_result, data_exception, e.res, e.exc);
            end
            $display("op %s A=%h B=%h -> result=%h exc=%b lat=%0d", m ? "MULT" : "DIV", a, b, data_result, data_exception, lat);
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_abort();
        test_reset_mid_op();
        test_both_pulses();
        test_back_to_back();
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
